// File: rtl/i2s_mclk_deser_pkg.sv
// Shared constants and helpers for the oversampling I2S deserializer.
package i2s_mclk_deser_pkg;

   // Frame-lock FSM encoding, also visible on the debug state output.
   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   // Legal slot length window in bck cycles.
   localparam logic [6:0] MIN_SLOT_BITS = 7'd16;
   localparam logic [6:0] MAX_SLOT_BITS = 7'd64;

   function automatic logic slot_legal(input logic [6:0] n);
      return (n >= MIN_SLOT_BITS) && (n <= MAX_SLOT_BITS);
   endfunction

   // Bit counter increment that sticks at 127.
   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      return (v == 7'd127) ? v : v + 7'd1;
   endfunction

   // Short slots carry fewer than 32 bits in the low end; move them to the MSBs.
   function automatic logic [31:0] msb_align(input logic [31:0] sr, input logic [6:0] n);
      if (n >= 7'd32) return sr;
      return sr << (7'd32 - n);
   endfunction

endpackage

// File: rtl/i2s_mclk_deser_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge detect.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic in,
   output logic out,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   assign out = chain[SYNC_STAGES-1];

   // Shift the async input through the chain and flag a 0->1 transition one clk later.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         chain <= '0;
         prev  <= 1'b0;
         rise  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], in};
         prev  <= chain[SYNC_STAGES-1];
         rise  <= chain[SYNC_STAGES-1] & ~prev;
      end
   end

endmodule

// File: rtl/i2s_mclk_deser.sv
// I2S deserializer oversampled in the mclk domain: slot assembly, frame-lock FSM
// and bck-loss watchdog. valid is a one-clk pulse with data = {left, right}.
module i2s_mclk_deser
   import i2s_mclk_deser_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FRAMES = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        bck_in,
   input  logic        lrck_in,
   input  logic        data_in,
   output logic [63:0] data,
   output logic        valid,
   output logic        locked,
   output logic [6:0]  bits_per_slot,
   output logic        err,
   output logic [1:0]  state
);

   localparam int             WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
   localparam logic [3:0]      LOCK_N  = 4'(LOCK_FRAMES);

   logic tick, lrck_s, data_s, bck_s;
   logic lrck_rise_unused, data_rise_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bck  (.clk(clk), .resetn(resetn), .in(bck_in),
                                                  .out(bck_s), .rise(tick));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (.clk(clk), .resetn(resetn), .in(lrck_in),
                                                  .out(lrck_s), .rise(lrck_rise_unused));
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (.clk(clk), .resetn(resetn), .in(data_in),
                                                  .out(data_s), .rise(data_rise_unused));

   logic            lrck_prev;
   logic [6:0]      bitcnt;
   logic [31:0]     sr;
   logic [31:0]     left_word;
   logic [6:0]      left_n;
   logic [6:0]      prev_n;
   logic [3:0]      frame_cnt;
   logic [WD_W-1:0] wd;

   logic [31:0] sr_next, word_close;
   logic [6:0]  n_close;
   logic        lr_edge, left_done, frame_done, frame_ok, left_bad, timeout;

   // Next-bit shift, slot close values and the frame consistency verdict.
   always_comb begin
      sr_next    = (bitcnt < 7'd32) ? {sr[30:0], data_s} : sr;
      n_close    = sat_inc7(bitcnt);
      word_close = msb_align(sr_next, n_close);
      lr_edge    = tick && (lrck_s != lrck_prev);
      left_done  = lr_edge && !lrck_prev;
      frame_done = lr_edge && lrck_prev;
      frame_ok   = (left_n == n_close) && slot_legal(n_close);
      if (state == LOCKED) frame_ok = frame_ok && (n_close == bits_per_slot);
      else                 frame_ok = frame_ok && ((frame_cnt == 4'd0) || (n_close == prev_n));
      left_bad   = left_done && (state == LOCKED) && (n_close != bits_per_slot);
      timeout    = !tick && (wd == WD_LAST);
   end

   // Slot assembly: shift bits on each tick, close the slot when lrck toggles.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lrck_prev <= 1'b0;
         bitcnt    <= '0;
         sr        <= '0;
         left_word <= '0;
         left_n    <= '0;
      end else if (tick) begin
         lrck_prev <= lrck_s;
         if (lr_edge) begin
            bitcnt <= '0;
            sr     <= '0;
            if (left_done) begin
               left_word <= word_close;
               left_n    <= n_close;
            end
         end else begin
            bitcnt <= n_close;
            sr     <= sr_next;
         end
      end
   end

   // Watchdog: cleared by every tick, counts up otherwise and sticks at TIMEOUT.
   always_ff @(posedge clk) begin
      if (!resetn)           wd <= '0;
      else if (tick)         wd <= '0;
      else if (wd != WD_MAX) wd <= wd + WD_W'(1);
   end

   // Lock FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= HUNT;
         frame_cnt     <= '0;
         prev_n        <= '0;
         data          <= '0;
         valid         <= 1'b0;
         locked        <= 1'b0;
         bits_per_slot <= '0;
         err           <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         case (state)
            HUNT: begin
               if (frame_done) begin
                  state     <= CHECK;
                  frame_cnt <= '0;
               end
            end
            CHECK: begin
               if (timeout) begin
                  state <= HUNT;
                  err   <= 1'b1;
               end else if (frame_done) begin
                  if (frame_ok) begin
                     frame_cnt <= frame_cnt + 4'd1;
                     prev_n    <= n_close;
                     if (frame_cnt + 4'd1 == LOCK_N) begin
                        state         <= LOCKED;
                        locked        <= 1'b1;
                        bits_per_slot <= n_close;
                     end
                  end else begin
                     state <= HUNT;
                     err   <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (timeout || left_bad || (frame_done && !frame_ok)) begin
                  state         <= HUNT;
                  err           <= 1'b1;
                  locked        <= 1'b0;
                  bits_per_slot <= '0;
               end else if (frame_done) begin
                  valid <= 1'b1;
                  data  <= {left_word, word_close};
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_mclk_deser.sv
// Directed bench for i2s_mclk_deser with a valid/err scoreboard.
module tb_i2s_mclk_deser;

   localparam int SYNC_STAGES = 2;
   localparam int LOCK_FRAMES = 4;
   localparam int TIMEOUT     = 1024;
   localparam int LAT         = SYNC_STAGES + 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        bck_in = 1'b0, lrck_in = 1'b0, data_in = 1'b0;
   logic [63:0] data;
   logic        valid, locked, err;
   logic [6:0]  bits_per_slot;
   logic [1:0]  state;

   i2s_mclk_deser #(.SYNC_STAGES(SYNC_STAGES), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .bck_in(bck_in), .lrck_in(lrck_in), .data_in(data_in),
      .data(data), .valid(valid), .locked(locked), .bits_per_slot(bits_per_slot),
      .err(err), .state(state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q[$];
   int          exp_cyc_q[$];
   int          err_cyc_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Frame-level reference model.
   int          m_state = 0, m_cnt = 0, m_prev_n = 0, m_bps = 0;
   logic        last_lr = 1'b0, carry = 1'b0;
   logic [63:0] pend_l = '0, pend_r = '0;
   int          pend_nl = 0, pend_nr = 0;
   int          last_pin = 0;

   function automatic logic [31:0] align32(input logic [63:0] w, input int n);
      logic [63:0] t;
      if (n >= 32) t = w >> (n - 32);
      else         t = w << (32 - n);
      return t[31:0];
   endfunction

   task automatic frame_done_model(input int pin_cyc);
      bit ok;
      ok = (pend_nl == pend_nr) && (pend_nl >= 16) && (pend_nl <= 64);
      case (m_state)
         0: begin m_state = 1; m_cnt = 0; end
         1: begin
            if (ok && (m_cnt == 0 || pend_nl == m_prev_n)) begin
               m_cnt++;
               m_prev_n = pend_nl;
               if (m_cnt == LOCK_FRAMES) begin m_state = 2; m_bps = pend_nl; end
            end else begin
               m_state = 0;
               err_cyc_q.push_back(pin_cyc + LAT);
            end
         end
         default: begin
            if (ok && pend_nl == m_bps) begin
               exp_q.push_back({align32(pend_l, pend_nl), align32(pend_r, pend_nr)});
               exp_cyc_q.push_back(pin_cyc);
            end else begin
               m_state = 0; m_bps = 0;
               err_cyc_q.push_back(pin_cyc + LAT);
            end
         end
      endcase
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (resetn) begin
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_valid: data %h at cycle %0d, none expected", data, cyc);
            end else begin
               check("valid_data", data, exp_q.pop_front());
               check("valid_latency", 64'(cyc - exp_cyc_q.pop_front()), 64'(LAT));
            end
         end
         if (err) begin
            if (err_cyc_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_err: at cycle %0d, none expected", cyc);
            end else begin
               check("err_cycle", 64'(cyc), 64'(err_cyc_q.pop_front()));
            end
         end
      end
   end

   // One bck period: data/lrck change on the falling edge, 8 clk per bck.
   task automatic bit_cycle(input logic lr, input logic d);
      bit completes;
      completes = (lr == 1'b0) && (last_lr == 1'b1);
      bck_in = 1'b0; lrck_in = lr; data_in = d;
      repeat (4) @(posedge clk);
      #2;
      bck_in = 1'b1;
      last_pin = cyc;
      if (completes) frame_done_model(cyc);
      last_lr = lr;
      repeat (4) @(posedge clk);
      #2;
   endtask

   // Standard I2S frame, MSB one bck after the lrck change; abort_at < 0 sends it whole.
   task automatic send_frame(input logic [63:0] l, input logic [63:0] r,
                             input int nl, input int nr, input int abort_at);
      for (int i = 0; i < nl; i++) bit_cycle(1'b0, (i == 0) ? carry : l[nl - i]);
      for (int i = 0; i < nr; i++) begin
         if (i == abort_at) return;
         bit_cycle(1'b1, (i == 0) ? l[0] : r[nr - i]);
      end
      carry = r[0];
      pend_l = l; pend_r = r; pend_nl = nl; pend_nr = nr;
   endtask

   task automatic check_status(input string tag, input logic exp_locked, input logic [6:0] exp_bps);
      check({tag, "_locked"}, 64'(locked), 64'(exp_locked));
      check({tag, "_bps"}, 64'(bits_per_slot), 64'(exp_bps));
   endtask

   task automatic do_reset(input string tag);
      resetn = 1'b0; bck_in = 1'b0; lrck_in = 1'b0; data_in = 1'b0;
      @(posedge clk);
      #2;
      check({tag, "_data"}, data, 64'd0);
      check({tag, "_valid"}, 64'(valid), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check_status(tag, 1'b0, 7'd0);
      repeat (2) @(posedge clk);
      #2;
      resetn = 1'b1;
      m_state = 0; m_cnt = 0; m_bps = 0; last_lr = 1'b0; carry = 1'b0;
   endtask

   task automatic frames32(input int count);
      for (int k = 0; k < count; k++)
         send_frame(64'hA5A50001, 64'h12345678, 32, 32, -1);
   endtask

   // Global time bound.
   initial begin
      #3000000;
      n_fail++;
      $display("FAIL time_limit: simulation did not complete at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      do_reset("reset");

      // Lock onto 32-bit slots.
      frames32(8);
      check_status("lock32", 1'b1, 7'd32);
      check("hold32", data, 64'hA5A50001_12345678);

      // Short right slot while locked.
      send_frame(64'hA5A50001, 64'h123456, 32, 24, -1);
      frames32(1);
      check_status("short_right", 1'b0, 7'd0);
      frames32(7);
      check_status("relock32", 1'b1, 7'd32);

      // bck stops while locked.
      bck_in = 1'b0;
      if (m_state != 0) err_cyc_q.push_back(last_pin + LAT + TIMEOUT);
      m_state = 0; m_bps = 0;
      repeat (TIMEOUT + 40) @(posedge clk);
      #2;
      check_status("timeout", 1'b0, 7'd0);

      // Relock, then reset in the middle of a right slot.
      frames32(8);
      check_status("pre_reset", 1'b1, 7'd32);
      send_frame(64'h0F0F0F0F, 64'hCAFEBABE, 32, 32, 10);
      do_reset("mid_reset");
      frames32(8);
      check_status("post_reset", 1'b1, 7'd32);
      check("hold_post_reset", data, 64'hA5A50001_12345678);

      // 16-bit slots.
      do_reset("reset16");
      for (int k = 0; k < 8; k++) send_frame(64'h8001, 64'h7FFE, 16, 16, -1);
      check_status("lock16", 1'b1, 7'd16);
      check("hold16", data, 64'h80010000_7FFE0000);

      // 64-bit slots with random low words.
      do_reset("reset64");
      for (int k = 0; k < 8; k++)
         send_frame({32'hDEADBEEF, 32'($urandom_range(32'hFFFFFFFF, 0))},
                    {32'h0BADF00D, 32'($urandom_range(32'hFFFFFFFF, 0))}, 64, 64, -1);
      check_status("lock64", 1'b1, 7'd64);
      check("hold64", data, 64'hDEADBEEF_0BADF00D);

      repeat (40) @(posedge clk);
      #2;
      check("valid_queue_drained", 64'(exp_q.size()), 64'd0);
      check("err_queue_drained", 64'(err_cyc_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
